vec_strided_lsu: RTL

Strided vector load/store sequencer for the vector coprocessor. It accepts one decoded `vlse.v`/`vsse.v` command: base, byte stride, vl, SEW and register. It walks the elements one at a time over a picorv32-style memory port. Loads write each element to the vector register file (VRF); stores read each element from the VRF and write it to memory. It sits between the coprocessor decode/issue stage and the shared memory port.

---
 rtl/vec_pkg.sv | 21 ++
 rtl/vec_lane_align.sv | 53 +++++
 rtl/vec_strided_lsu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared vector-coprocessor definitions: SEW encodings, the memory-op
// encoding of strided accesses, and the LSU sequencer state encoding.
package vec_pkg;

    // Element width (SEW) field encodings; 2'b11 is reserved/illegal.
    localparam logic [1:0] SEW_E8  = 2'b00;
    localparam logic [1:0] SEW_E16 = 2'b01;
    localparam logic [1:0] SEW_E32 = 2'b10;

    // mop field value that selects a strided access.
    localparam logic [1:0] MOP_STRIDED = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

endpackage

// File: rtl/vec_lane_align.sv
// Byte-lane alignment for one vector element on a 32-bit memory word.
// Shared by the strided and unit-stride LSUs.
//   sew       : element width encoding (vec_pkg SEW_*)
//   lane      : byte offset of the element inside the word
//   wdata_in  : right-aligned store element
//   rdata_in  : raw memory read word
//   wdata_out : store element shifted onto its lane
//   wstrb     : byte enables for the store
//   rdata_out : load element extracted and zero-extended
//   misalign  : element straddles its natural alignment, or sew is illegal
module vec_lane_align
    import vec_pkg::*;
(
    input  logic [1:0]  sew,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_out,
    output logic        misalign
);

    logic [4:0]  shamt;
    logic [31:0] rdata_sh;

    always_comb begin
        shamt     = {lane, 3'b000};
        wdata_out = wdata_in << shamt;
        rdata_sh  = rdata_in >> shamt;
        wstrb     = 4'b0000;
        rdata_out = 32'd0;
        misalign  = 1'b0;
        case (sew)
            SEW_E8: begin
                wstrb     = 4'b0001 << lane;
                rdata_out = {24'd0, rdata_sh[7:0]};
            end
            SEW_E16: begin
                wstrb     = 4'b0011 << lane;
                rdata_out = {16'd0, rdata_sh[15:0]};
                misalign  = lane[0];
            end
            SEW_E32: begin
                wstrb     = 4'b1111 << lane;
                rdata_out = rdata_sh;
                misalign  = |lane;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store sequencer (vlse.v / vsse.v). Accepts one decoded
// command and walks its elements one at a time over a picorv32-style memory
// port, moving data between memory and the vector register file.
//   cmd_*     : command handshake and fields (base, signed stride, vl, sew, vreg)
//   mem_*     : picorv32 memory port (valid/ready, word address, wdata/wstrb/rdata)
//   vrf_r*    : VRF read port for store data, 1-cycle read latency
//   vrf_w*    : VRF write port for load data, element zero-extended
//   busy      : a command is in progress
//   done/err  : one-cycle completion pulse, err flags misalignment or bad sew
module vec_strided_lsu
    import vec_pkg::*;
#(
    parameter int VL_W   = 5,
    parameter int VREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_store,
    input  logic [31:0]       cmd_base,
    input  logic [31:0]       cmd_stride,
    input  logic [VL_W:0]     cmd_vl,
    input  logic [1:0]        cmd_sew,
    input  logic [VREG_W-1:0] cmd_vreg,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic [VREG_W-1:0] vrf_raddr,
    output logic [VL_W-1:0]   vrf_ridx,
    input  logic [31:0]       vrf_rdata,
    output logic              vrf_we,
    output logic [VREG_W-1:0] vrf_waddr,
    output logic [VL_W-1:0]   vrf_widx,
    output logic [31:0]       vrf_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    lsu_state_t         state_q, state_d;
    logic               store_q;
    logic [31:0]        addr_q;
    logic signed [31:0] stride_q;
    logic [VL_W:0]      vl_q;
    logic [1:0]         sew_q;
    logic [VREG_W-1:0]  vreg_q;
    logic [VL_W-1:0]    idx_q;
    logic [31:0]        ld_data_q;
    logic               err_q;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic        misalign;
    logic        last_elem;
    logic        st_req;

    vec_lane_align u_align (
        .sew       (sew_q),
        .lane      (addr_q[1:0]),
        .wdata_in  (vrf_rdata),
        .rdata_in  (mem_rdata),
        .wdata_out (st_wdata),
        .wstrb     (st_wstrb),
        .rdata_out (ld_data),
        .misalign  (misalign)
    );

    assign last_elem = ({1'b0, idx_q} == (vl_q - (VL_W+1)'(1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_vl == '0)   state_d = ST_DONE;
                    else if (cmd_store) state_d = ST_FETCH;
                    else                state_d = ST_REQ;
                end
            end
            ST_FETCH: state_d = ST_REQ;
            ST_REQ: begin
                if (misalign)       state_d = ST_DONE;
                else if (mem_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (last_elem)    state_d = ST_DONE;
                else if (store_q) state_d = ST_FETCH;
                else              state_d = ST_REQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            store_q   <= 1'b0;
            addr_q    <= 32'd0;
            stride_q  <= 32'sd0;
            vl_q      <= '0;
            sew_q     <= SEW_E8;
            vreg_q    <= '0;
            idx_q     <= '0;
            ld_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        store_q  <= cmd_store;
                        addr_q   <= cmd_base;
                        stride_q <= $signed(cmd_stride);
                        vl_q     <= cmd_vl;
                        sew_q    <= cmd_sew;
                        vreg_q   <= cmd_vreg;
                        idx_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (misalign)
                        err_q <= 1'b1;
                    else if (mem_ready && !store_q)
                        ld_data_q <= ld_data;
                end
                ST_RESP: begin
                    if (!last_elem) begin
                        idx_q  <= idx_q + 1'b1;
                        // Two's-complement add gives the mod-2^32 wrap for
                        // negative strides.
                        addr_q <= addr_q + $unsigned(stride_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // vrf_raddr/vrf_ridx stay stable from FETCH through REQ, so the VRF's
    // registered read output holds the store element for the whole request.
    assign st_req    = (state_q == ST_REQ) && store_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && err_q;

    assign mem_valid = (state_q == ST_REQ) && !misalign;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = st_req ? st_wdata : 32'd0;
    assign mem_wstrb = st_req ? st_wstrb : 4'b0000;

    assign vrf_raddr = vreg_q;
    assign vrf_ridx  = idx_q;
    assign vrf_we    = (state_q == ST_RESP) && !store_q;
    assign vrf_waddr = vreg_q;
    assign vrf_widx  = idx_q;
    assign vrf_wdata = ld_data_q;

endmodule
